// File: rtl/ipd_terms.sv
// I-PD front-end: captures setpoint/measurement per sample strobe, updates integral and derivative terms, pulses compute.
// Optional macro IPD_ANTIWINDUP_EN saturates the integral term instead of wrapping it.
module ipd_terms #(
  parameter logic [5:0] KI = 6'd3,
  parameter logic [7:0] KD = 8'd20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample,
  input  logic signed [8:0]  rk,
  input  logic signed [8:0]  ym,
  output logic signed [16:0] ik,
  output logic signed [8:0]  yk,
  output logic signed [18:0] dk,
  output logic               compute,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, INTEG, DERIV, ISSUE} state_t;

  state_t             state, state_nx;
  logic signed [8:0]  rk_c, ym_c, y_prev;
  logic               first;
  logic signed [9:0]  err, dy;
  logic signed [16:0] ki_prod;
  logic signed [17:0] isum;
  logic signed [17:0] kd_prod;
  logic signed [16:0] ik_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (sample) state_nx = INTEG;
      INTEG:   state_nx = DERIV;
      DERIV:   state_nx = ISSUE;
      ISSUE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    err     = 10'(rk_c) - 10'(ym_c);
    dy      = 10'(ym_c) - 10'(y_prev);
    ki_prod = 17'($signed({1'b0, KI})) * 17'(err);
    kd_prod = 18'($signed({1'b0, KD})) * 18'(dy);
    isum    = 18'(ik) + 18'(ki_prod);
  end

`ifdef IPD_ANTIWINDUP_EN
  always_comb begin
    if (isum[17] != isum[16])
      ik_nx = isum[17] ? 17'sh10000 : 17'sh0FFFF;
    else
      ik_nx = isum[16:0];
  end
`else
  always_comb begin
    ik_nx = isum[16:0];
  end
`endif

  // compute is registered out of ISSUE, so busy is stretched one cycle past the FSM to cover it
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rk_c    <= '0;
      ym_c    <= '0;
      ik      <= '0;
      yk      <= '0;
      dk      <= '0;
      y_prev  <= '0;
      first   <= 1'b1;
      compute <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      compute <= (state == ISSUE);
      busy    <= (state_nx != IDLE) || (state == ISSUE);
      if (state == IDLE && sample) begin
        rk_c <= rk;
        ym_c <= ym;
      end
      if (state == INTEG)
        ik <= ik_nx;
      if (state == DERIV) begin
        dk     <= first ? '0 : 19'(kd_prod);
        yk     <= ym_c;
        y_prev <= ym_c;
        first  <= 1'b0;
      end
    end
  end

endmodule
